// File: rtl/key_pkg.sv
// Shared defaults and key ID constants for the key event path of the power-controller UI.
package key_pkg;
    localparam int KEY_NUM_DEF    = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_OK   = 2;
    localparam int KEY_BACK = 3;
endpackage

// File: rtl/evt_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; registered storage, combinational head read.
module evt_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Push and pop are gated here so callers may request freely.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/key_event_arbiter.sv
// Latches key press pulses, picks one pending key per cycle round-robin and queues its ID.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int KEY_NUM    = KEY_NUM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ID_W      = $clog2(KEY_NUM),
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_pulse,
    input  logic               evt_ready,
    input  logic               clr_lost,
    output logic               evt_valid,
    output logic [ID_W-1:0]    evt_id,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [KEY_NUM-1:0] pend,
    output logic               lost
);
    // Handshake: evt_id is meaningful while evt_valid=1; the head is consumed on
    // each rising edge where evt_valid && evt_ready; evt_ready with evt_valid=0 is ignored.

    logic [ID_W-1:0]    last_gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic [KEY_NUM-1:0] gnt_vec;
    logic               merge;
    logic               fifo_full;
    logic               fifo_empty;
    int                 idx;

    // Full comes from registered pointers, so a pop this cycle cannot make room for a push.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        if (!fifo_full) begin
            for (int k = 1; k <= KEY_NUM; k++) begin
                idx = (int'(last_gnt) + k) % KEY_NUM;
                if (!gnt_valid && pend[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ID_W'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        gnt_vec[gnt_id] = gnt_valid;
    end

    assign merge = |(key_pulse & pend & ~gnt_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            lost     <= 1'b0;
            last_gnt <= ID_W'(KEY_NUM - 1);
        end else begin
            pend <= (pend & ~gnt_vec) | key_pulse;
            if (merge) begin
                lost <= 1'b1;
            end else if (clr_lost) begin
                lost <= 1'b0;
            end
            if (gnt_valid) begin
                last_gnt <= gnt_id;
            end
        end
    end

    evt_fifo #(
        .W     (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (gnt_valid),
        .din   (gnt_id),
        .pop   (evt_ready),
        .dout  (evt_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign evt_valid = !fifo_empty;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Scenario bench for key_event_arbiter: expected key IDs are queued at stimulus time and checked at pop.
module tb_key_event_arbiter;
    import key_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_pulse;
    logic       evt_ready;
    logic       clr_lost;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [2:0] fifo_level;
    logic [3:0] pend;
    logic       lost;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    key_event_arbiter #(
        .KEY_NUM    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_pulse  (key_pulse),
        .evt_ready  (evt_ready),
        .clr_lost   (clr_lost),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .fifo_level (fifo_level),
        .pend       (pend),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end on a falling edge; inputs change there, outputs are sampled there.
    task automatic do_reset();
        key_pulse = '0;
        evt_ready = 1'b0;
        clr_lost  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse(input logic [3:0] mask);
        key_pulse = mask;
        @(negedge clk);
        key_pulse = '0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        logic [1:0] exp;
        n = 0;
        evt_ready = 1'b1;
        while (exp_q.size() > 0 && n < max_cycles) begin
            if (evt_valid) begin
                exp = exp_q.pop_front();
                checks++;
                if (evt_id !== exp) begin
                    failures++;
                    $display("FAIL drain_id got=%0d exp=%0d", evt_id, exp);
                end
            end
            @(negedge clk);
            n++;
        end
        evt_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout remaining=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic fill_all();
        pulse(4'b1111);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        key_pulse = '0;
        evt_ready = 1'b0;
        clr_lost  = 1'b0;
        rst_n     = 1'b0;
        #12;
        checks++;
        if (evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", evt_valid); end
        checks++;
        if (evt_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", evt_id); end
        checks++;
        if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++;
        if (pend !== 4'b0000) begin failures++; $display("FAIL reset_pend got=%b exp=0000", pend); end
        checks++;
        if (lost !== 1'b0) begin failures++; $display("FAIL reset_lost got=%0b exp=0", lost); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        do_reset();
        pulse(4'b0100);
        exp_q.push_back(2'(KEY_OK));
        checks++;
        if (evt_valid !== 1'b0 || pend !== 4'b0100) begin
            failures++;
            $display("FAIL lat_first_edge got=valid%0b/pend%b exp=valid0/pend0100", evt_valid, pend);
        end
        @(negedge clk);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            failures++;
            $display("FAIL lat_second_edge got=valid%0b/id%0d exp=valid1/id2", evt_valid, evt_id);
        end
        checks++;
        if (fifo_level !== 3'd1 || pend !== 4'b0000 || lost !== 1'b0) begin
            failures++;
            $display("FAIL lat_status got=lvl%0d/pend%b/lost%0b exp=lvl1/pend0000/lost0", fifo_level, pend, lost);
        end
        drain(4);
        checks++;
        if (evt_valid !== 1'b0) begin failures++; $display("FAIL lat_empty got=%0b exp=0", evt_valid); end
    endtask

    task automatic test_all_keys();
        do_reset();
        pulse(4'b1111);
        checks++;
        if (pend !== 4'b1111) begin failures++; $display("FAIL all_pend got=%b exp=1111", pend); end
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd4 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL all_full got=lvl%0d/pend%b exp=lvl4/pend0000", fifo_level, pend);
        end
        drain(8);
        checks++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin
            failures++;
            $display("FAIL all_drained got=valid%0b/lvl%0d exp=valid0/lvl0", evt_valid, fifo_level);
        end
    endtask

    task automatic test_full_hold();
        logic [1:0] exp;
        do_reset();
        fill_all();
        pulse(4'b0010);
        exp_q.push_back(2'd1);
        @(negedge clk);
        checks++;
        if (pend !== 4'b0010 || fifo_level !== 3'd4 || lost !== 1'b0) begin
            failures++;
            $display("FAIL full_hold got=pend%b/lvl%0d/lost%0b exp=pend0010/lvl4/lost0", pend, fifo_level, lost);
        end
        evt_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (evt_id !== exp) begin failures++; $display("FAIL full_pop_id got=%0d exp=%0d", evt_id, exp); end
        @(negedge clk);
        evt_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd3 || pend !== 4'b0010) begin
            failures++;
            $display("FAIL full_after_pop got=lvl%0d/pend%b exp=lvl3/pend0010", fifo_level, pend);
        end
        @(negedge clk);
        checks++;
        if (fifo_level !== 3'd4 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL full_refill got=lvl%0d/pend%b exp=lvl4/pend0000", fifo_level, pend);
        end
        drain(10);
    endtask

    task automatic test_merge_lost();
        do_reset();
        fill_all();
        pulse(4'b1000);
        exp_q.push_back(2'd3);
        checks++;
        if (lost !== 1'b0) begin failures++; $display("FAIL merge_pre_lost got=%0b exp=0", lost); end
        pulse(4'b1000);
        checks++;
        if (lost !== 1'b1 || pend !== 4'b1000) begin
            failures++;
            $display("FAIL merge_set got=lost%0b/pend%b exp=lost1/pend1000", lost, pend);
        end
        clr_lost = 1'b1;
        pulse(4'b1000);
        clr_lost = 1'b0;
        checks++;
        if (lost !== 1'b1) begin failures++; $display("FAIL merge_set_wins got=%0b exp=1", lost); end
        clr_lost = 1'b1;
        @(negedge clk);
        clr_lost = 1'b0;
        checks++;
        if (lost !== 1'b0) begin failures++; $display("FAIL merge_clear got=%0b exp=0", lost); end
        drain(12);
        repeat (3) @(negedge clk);
        checks++;
        if (evt_valid !== 1'b0 || pend !== 4'b0000) begin
            failures++;
            $display("FAIL merge_single_event got=valid%0b/pend%b exp=valid0/pend0000", evt_valid, pend);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp;
        do_reset();
        pulse(4'b0001);
        exp_q.push_back(2'd0);
        drain(6);
        clr_lost = 1'b1;
        @(negedge clk);
        clr_lost = 1'b0;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        key_pulse = 4'b0011;
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) key_pulse = '0;
            if (i == 2) begin
                checks++;
                if (pend !== 4'b0011) begin failures++; $display("FAIL fair_pend_held got=%b exp=0011", pend); end
            end
            if (evt_valid && exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                checks++;
                if (evt_id !== exp) begin failures++; $display("FAIL fair_order step=%0d got=%0d exp=%0d", i, evt_id, exp); end
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL fair_done got=left%0d/valid%0b exp=left0/valid0", exp_q.size(), evt_valid);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp;
        do_reset();
        fill_all();
        key_pulse = 4'b0001;
        evt_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (evt_id !== exp) begin failures++; $display("FAIL mid_pop_id got=%0d exp=%0d", evt_id, exp); end
        @(negedge clk);
        key_pulse = '0;
        evt_ready = 1'b0;
        checks++;
        if (fifo_level !== 3'd3 || pend !== 4'b0001) begin
            failures++;
            $display("FAIL mid_setup got=lvl%0d/pend%b exp=lvl3/pend0001", fifo_level, pend);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0 || pend !== 4'b0000 || lost !== 1'b0) begin
            failures++;
            $display("FAIL mid_async got=valid%0b/lvl%0d/pend%b/lost%0b exp=0/0/0000/0", evt_valid, fifo_level, pend, lost);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fill_all();
        drain(8);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_all_keys();
        test_full_hold();
        test_merge_lost();
        test_fairness();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
